// File: rtl/pipe_cpu_1.sv
// pipe_cpu_1: 5-stage in-order MIPS-subset CPU (IF/ID/EX/MEM/WB) with private IM, RF and DM.
// Build option: define FORWARD_EN to forward EX/MEM and MEM/WB results into the EX-stage ALU operands.
module pipe_cpu_1 #(
   parameter int IM_WORDS = 32,
   parameter int DM_BYTES = 128
) (
   input  logic clk_i,
   input  logic rst_i
);
   localparam int IA = $clog2(IM_WORDS);
   localparam int DA = $clog2(DM_BYTES);

   typedef enum logic [2:0] {ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                             ALU_OR = 3'd3, ALU_SLT = 3'd4} alu_op_t;

   logic [31:0] pc_r, pc4_s, instr_s, if_id_instr_r, if_id_pc4_r;
   logic [5:0]  op_s, funct_s;
   logic [4:0]  rs_s, rt_s, rd_s, wreg_s;
   logic [31:0] imm_s, rs_val_s, rt_val_s;
   logic        reg_write_s, mem_to_reg_s, mem_write_s, branch_s, alu_src_s;
   alu_op_t     alu_op_s;

   logic [31:0] id_ex_a_r, id_ex_b_r, id_ex_imm_r, id_ex_pc4_r;
   logic [4:0]  id_ex_rs_r, id_ex_rt_r, id_ex_wreg_r;
   logic        id_ex_reg_write_r, id_ex_mem_to_reg_r, id_ex_mem_write_r, id_ex_branch_r, id_ex_alu_src_r;
   alu_op_t     id_ex_alu_op_r;

   logic [31:0] opa_s, opb_reg_s, opb_s, alu_s, br_target_s;
   logic [31:0] ex_mem_alu_r, ex_mem_store_r, ex_mem_target_r;
   logic [4:0]  ex_mem_wreg_r;
   logic        ex_mem_reg_write_r, ex_mem_mem_to_reg_r, ex_mem_mem_write_r, ex_mem_taken_r;

   logic [31:0] dm_rdata_s, mem_wb_data_r;
   logic [4:0]  mem_wb_wreg_r;
   logic        mem_wb_reg_write_r;
   logic        unused_s;

   assign pc4_s    = pc_r + 32'd4;
   assign op_s     = if_id_instr_r[31:26];
   assign rs_s     = if_id_instr_r[25:21];
   assign rt_s     = if_id_instr_r[20:16];
   assign rd_s     = if_id_instr_r[15:11];
   assign funct_s  = if_id_instr_r[5:0];
   assign imm_s    = {{16{if_id_instr_r[15]}}, if_id_instr_r[15:0]};
   assign unused_s = ^{if_id_instr_r[10:6], id_ex_imm_r[31:30]};

   // The write port exists for an external loader; this core never writes its own program.
   pipe_cpu_1_im #(.IM_WORDS(IM_WORDS), .IA(IA)) IM (
      .clk_i(clk_i), .we(1'b0), .waddr({IA{1'b0}}), .wdata(32'd0),
      .raddr(pc_r[IA+1:2]), .rdata(instr_s));

   pipe_cpu_1_rf RF (
      .clk_i(clk_i), .rst_i(rst_i), .ra1(rs_s), .ra2(rt_s), .rd1(rs_val_s), .rd2(rt_val_s),
      .we(mem_wb_reg_write_r), .wa(mem_wb_wreg_r), .wd(mem_wb_data_r));

   pipe_cpu_1_dm #(.DM_BYTES(DM_BYTES), .DA(DA)) DM (
      .clk_i(clk_i), .we(ex_mem_mem_write_r), .waddr(ex_mem_alu_r[DA-1:2]),
      .wdata(ex_mem_store_r), .rdata(dm_rdata_s));

   // Fetch: PC advances by 4 unless a branch resolved in MEM redirects it
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         pc_r          <= 32'd0;
         if_id_instr_r <= 32'd0;
         if_id_pc4_r   <= 32'd0;
      end else begin
         pc_r          <= ex_mem_taken_r ? ex_mem_target_r : pc4_s;
         if_id_instr_r <= instr_s;
         if_id_pc4_r   <= pc4_s;
      end
   end

   // Decode: anything not recognised leaves every control low, i.e. a nop
   always_comb begin
      reg_write_s = 1'b0; mem_to_reg_s = 1'b0; mem_write_s = 1'b0;
      branch_s = 1'b0; alu_src_s = 1'b0; alu_op_s = ALU_ADD; wreg_s = rt_s;
      case (op_s)
         6'h00: begin
            wreg_s = rd_s;
            case (funct_s)
               6'h20:   begin reg_write_s = 1'b1; alu_op_s = ALU_ADD; end
               6'h22:   begin reg_write_s = 1'b1; alu_op_s = ALU_SUB; end
               6'h24:   begin reg_write_s = 1'b1; alu_op_s = ALU_AND; end
               6'h25:   begin reg_write_s = 1'b1; alu_op_s = ALU_OR;  end
               6'h2A:   begin reg_write_s = 1'b1; alu_op_s = ALU_SLT; end
               default: reg_write_s = 1'b0;
            endcase
         end
         6'h08:   begin reg_write_s = 1'b1; alu_src_s = 1'b1; end
         6'h0A:   begin reg_write_s = 1'b1; alu_src_s = 1'b1; alu_op_s = ALU_SLT; end
         6'h23:   begin reg_write_s = 1'b1; mem_to_reg_s = 1'b1; alu_src_s = 1'b1; end
         6'h2B:   begin mem_write_s = 1'b1; alu_src_s = 1'b1; end
         6'h04:   begin branch_s = 1'b1; alu_op_s = ALU_SUB; end
         default: reg_write_s = 1'b0;
      endcase
   end

   // ID/EX pipeline register
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         id_ex_a_r <= 32'd0; id_ex_b_r <= 32'd0; id_ex_imm_r <= 32'd0; id_ex_pc4_r <= 32'd0;
         id_ex_rs_r <= 5'd0; id_ex_rt_r <= 5'd0; id_ex_wreg_r <= 5'd0;
         id_ex_reg_write_r <= 1'b0; id_ex_mem_to_reg_r <= 1'b0; id_ex_mem_write_r <= 1'b0;
         id_ex_branch_r <= 1'b0; id_ex_alu_src_r <= 1'b0; id_ex_alu_op_r <= ALU_ADD;
      end else begin
         id_ex_a_r <= rs_val_s; id_ex_b_r <= rt_val_s; id_ex_imm_r <= imm_s; id_ex_pc4_r <= if_id_pc4_r;
         id_ex_rs_r <= rs_s; id_ex_rt_r <= rt_s; id_ex_wreg_r <= wreg_s;
         id_ex_reg_write_r <= reg_write_s; id_ex_mem_to_reg_r <= mem_to_reg_s;
         id_ex_mem_write_r <= mem_write_s; id_ex_branch_r <= branch_s;
         id_ex_alu_src_r <= alu_src_s; id_ex_alu_op_r <= alu_op_s;
      end
   end

`ifdef FORWARD_EN
   // Operand bypass: the younger EX/MEM result wins over MEM/WB writeback data
   always_comb begin
      if (ex_mem_reg_write_r && (ex_mem_wreg_r != 5'd0) && (ex_mem_wreg_r == id_ex_rs_r))
         opa_s = ex_mem_alu_r;
      else if (mem_wb_reg_write_r && (mem_wb_wreg_r != 5'd0) && (mem_wb_wreg_r == id_ex_rs_r))
         opa_s = mem_wb_data_r;
      else
         opa_s = id_ex_a_r;
      if (ex_mem_reg_write_r && (ex_mem_wreg_r != 5'd0) && (ex_mem_wreg_r == id_ex_rt_r))
         opb_reg_s = ex_mem_alu_r;
      else if (mem_wb_reg_write_r && (mem_wb_wreg_r != 5'd0) && (mem_wb_wreg_r == id_ex_rt_r))
         opb_reg_s = mem_wb_data_r;
      else
         opb_reg_s = id_ex_b_r;
   end
`else
   logic unused_fwd_s;
   assign unused_fwd_s = ^{id_ex_rs_r, id_ex_rt_r};
   assign opa_s        = id_ex_a_r;
   assign opb_reg_s    = id_ex_b_r;
`endif

   assign opb_s       = id_ex_alu_src_r ? id_ex_imm_r : opb_reg_s;
   assign br_target_s = id_ex_pc4_r + {id_ex_imm_r[29:0], 2'b00};

   // ALU; beq uses SUB and tests the result for zero
   always_comb begin
      case (id_ex_alu_op_r)
         ALU_ADD: alu_s = opa_s + opb_s;
         ALU_SUB: alu_s = opa_s - opb_s;
         ALU_AND: alu_s = opa_s & opb_s;
         ALU_OR:  alu_s = opa_s | opb_s;
         ALU_SLT: alu_s = ($signed(opa_s) < $signed(opb_s)) ? 32'd1 : 32'd0;
         default: alu_s = 32'd0;
      endcase
   end

   // EX/MEM pipeline register; the branch decision is carried here and acted on from MEM
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         ex_mem_alu_r <= 32'd0; ex_mem_store_r <= 32'd0; ex_mem_target_r <= 32'd0;
         ex_mem_wreg_r <= 5'd0; ex_mem_reg_write_r <= 1'b0; ex_mem_mem_to_reg_r <= 1'b0;
         ex_mem_mem_write_r <= 1'b0; ex_mem_taken_r <= 1'b0;
      end else begin
         ex_mem_alu_r <= alu_s; ex_mem_store_r <= opb_reg_s; ex_mem_target_r <= br_target_s;
         ex_mem_wreg_r <= id_ex_wreg_r; ex_mem_reg_write_r <= id_ex_reg_write_r;
         ex_mem_mem_to_reg_r <= id_ex_mem_to_reg_r; ex_mem_mem_write_r <= id_ex_mem_write_r;
         ex_mem_taken_r <= id_ex_branch_r && (alu_s == 32'd0);
      end
   end

   // MEM/WB pipeline register holding the final writeback value
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         mem_wb_data_r <= 32'd0; mem_wb_wreg_r <= 5'd0; mem_wb_reg_write_r <= 1'b0;
      end else begin
         mem_wb_data_r      <= ex_mem_mem_to_reg_r ? dm_rdata_s : ex_mem_alu_r;
         mem_wb_wreg_r      <= ex_mem_wreg_r;
         mem_wb_reg_write_r <= ex_mem_reg_write_r;
      end
   end
endmodule

module pipe_cpu_1_im #(
   parameter int IM_WORDS = 32,
   parameter int IA = 5
) (
   input  logic          clk_i,
   input  logic          we,
   input  logic [IA-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [IA-1:0] raddr,
   output logic [31:0]   rdata
);
   logic [31:0] instruction_file [0:IM_WORDS-1];

   // Loader write port; contents are deliberately not reset
   always_ff @(posedge clk_i) begin
      if (we) instruction_file[waddr] <= wdata;
   end
   assign rdata = instruction_file[raddr];
endmodule

module pipe_cpu_1_rf (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   output logic [31:0] rd1,
   output logic [31:0] rd2,
   input  logic        we,
   input  logic [4:0]  wa,
   input  logic [31:0] wd
);
   logic [31:0] Reg_File [0:31];

   // Writeback port; r0 is never written
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         for (int i = 0; i < 32; i++) Reg_File[i] <= 32'd0;
      end else if (we && (wa != 5'd0)) begin
         Reg_File[wa] <= wd;
      end
   end

   // Reads see a same-cycle WB write, so a producer three slots ahead needs no bypass
   always_comb begin
      if (ra1 == 5'd0)                rd1 = 32'd0;
      else if (we && (wa == ra1))     rd1 = wd;
      else                            rd1 = Reg_File[ra1];
      if (ra2 == 5'd0)                rd2 = 32'd0;
      else if (we && (wa == ra2))     rd2 = wd;
      else                            rd2 = Reg_File[ra2];
   end
endmodule

module pipe_cpu_1_dm #(
   parameter int DM_BYTES = 128,
   parameter int DA = 7
) (
   input  logic          clk_i,
   input  logic          we,
   input  logic [DA-3:0] waddr,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);
   logic [7:0]  Mem    [0:DM_BYTES-1];
   logic [31:0] memory [0:DM_BYTES/4-1];

   // Little-endian word store into the byte array
   always_ff @(posedge clk_i) begin
      if (we) begin
         Mem[{waddr, 2'b00}] <= wdata[7:0];
         Mem[{waddr, 2'b01}] <= wdata[15:8];
         Mem[{waddr, 2'b10}] <= wdata[23:16];
         Mem[{waddr, 2'b11}] <= wdata[31:24];
      end
   end

   // Word view of the byte array
   always_comb begin
      for (int k = 0; k < DM_BYTES/4; k++)
         memory[k] = {Mem[4*k+3], Mem[4*k+2], Mem[4*k+1], Mem[4*k]};
   end
   assign rdata = memory[waddr];
endmodule

// File: tb/tb_pipe_cpu_1.sv
// Self-checking bench for pipe_cpu_1: program tables carry expected register results into a scoreboard.
module tb_pipe_cpu_1;
   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

`ifdef FORWARD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   typedef struct { logic [31:0] instr; logic chk; logic [4:0] rg; logic [31:0] exp; } vec_t;
   typedef struct { logic [4:0] rg; logic [31:0] exp; } sb_t;

   vec_t vecs[$];
   sb_t  sb[$];

   pipe_cpu_1 dut (.clk_i(clk_i), .rst_i(rst_i));

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] r_op(input logic [5:0] fn, input logic [4:0] rd, rs, rt);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction
   function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic add(input logic [31:0] ins, input logic chk, input logic [4:0] rg, input logic [31:0] exp);
      vec_t v;
      v.instr = ins; v.chk = chk; v.rg = rg; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) add(32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   // Static so the loop index may appear in a nonblocking hierarchical store
   task load_prog;
      sb_t e;
      @(negedge clk_i);
      for (int i = 0; i < 32; i++) begin
         if (i < vecs.size()) dut.IM.instruction_file[i] <= vecs[i].instr;
         else                 dut.IM.instruction_file[i] <= 32'd0;
      end
      foreach (vecs[j]) begin
         if (vecs[j].chk) begin
            e.rg = vecs[j].rg; e.exp = vecs[j].exp;
            sb.push_back(e);
         end
      end
      vecs.delete();
   endtask

   task automatic reset_cpu();
      @(negedge clk_i); rst_i = 1'b0;
      @(negedge clk_i); rst_i = 1'b1;
   endtask

   task automatic run_prog(input string name, input int cycles);
      sb_t e;
      load_prog();
      reset_cpu();
      repeat (cycles) @(posedge clk_i);
      @(negedge clk_i);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("%s r%0d", name, e.rg), dut.RF.Reg_File[e.rg], e.exp);
      end
   endtask

   initial begin
      // Reset with garbage in PC, RF and pipeline; DM must survive
      @(negedge clk_i); rst_i = 1'b1;
      @(negedge clk_i);
      for (int i = 0; i < 32; i++) begin
         dut.RF.Reg_File[i] <= 32'hDEAD0000 | i;
         dut.IM.instruction_file[i] <= 32'd0;
      end
      for (int i = 0; i < 128; i++) dut.DM.Mem[i] <= 8'(i) ^ 8'hA5;
      dut.pc_r               <= 32'h0000_0040;
      dut.if_id_instr_r      <= i_op(6'h08, 5'd0, 5'd3, 16'd77);
      dut.mem_wb_reg_write_r <= 1'b1;
      dut.mem_wb_wreg_r      <= 5'd4;
      dut.mem_wb_data_r      <= 32'h1234_5678;
      reset_cpu();
      check("reset pc", dut.pc_r, 32'd0);
      for (int i = 0; i < 32; i++) check($sformatf("reset r%0d", i), dut.RF.Reg_File[i], 32'd0);
      check("reset dm byte 20", {24'd0, dut.DM.Mem[20]}, 32'h0000_00B1);
      repeat (6) @(posedge clk_i);
      @(negedge clk_i);
      check("reset pipe r3", dut.RF.Reg_File[3], 32'd0);
      check("reset pipe r4", dut.RF.Reg_File[4], 32'd0);

      // Latency: a lone addi lands in the RF on the 5th edge after release
      add(i_op(6'h08, 5'd0, 5'd1, 16'd7), 1'b0, 5'd0, 32'd0);
      load_prog();
      reset_cpu();
      repeat (4) @(posedge clk_i);
      @(negedge clk_i);
      check("latency edge4 r1", dut.RF.Reg_File[1], 32'd0);
      @(posedge clk_i);
      @(negedge clk_i);
      check("latency edge5 r1", dut.RF.Reg_File[1], 32'd7);
      check("latency edge5 pc", dut.pc_r, 32'd20);

      // ALU chain, dependents kept at least 3 slots from producers
      add(i_op(6'h08, 5'd0, 5'd1, 16'd10),     1'b1, 5'd1, 32'd10);
      add(i_op(6'h08, 5'd0, 5'd2, 16'd3),      1'b1, 5'd2, 32'd3);
      add(i_op(6'h08, 5'd0, 5'd7, 16'hFFFF),   1'b1, 5'd7, 32'hFFFF_FFFF);
      nops(3);
      add(r_op(6'h22, 5'd3, 5'd1, 5'd2),       1'b1, 5'd3, 32'd7);
      add(r_op(6'h2A, 5'd4, 5'd2, 5'd1),       1'b1, 5'd4, 32'd1);
      add(r_op(6'h24, 5'd5, 5'd1, 5'd2),       1'b1, 5'd5, 32'd2);
      add(r_op(6'h25, 5'd6, 5'd1, 5'd2),       1'b1, 5'd6, 32'd11);
      add(r_op(6'h2A, 5'd8, 5'd7, 5'd1),       1'b1, 5'd8, 32'd1);
      add(i_op(6'h0A, 5'd7, 5'd9, 16'd0),      1'b1, 5'd9, 32'd1);
      add(i_op(6'h0A, 5'd1, 5'd10, 16'hFFFE),  1'b1, 5'd10, 32'd0);
      add(r_op(6'h20, 5'd11, 5'd1, 5'd7),      1'b1, 5'd11, 32'd9);
      add(r_op(6'h22, 5'd12, 5'd2, 5'd1),      1'b1, 5'd12, 32'hFFFF_FFF9);
      add(r_op(6'h2A, 5'd13, 5'd1, 5'd7),      1'b1, 5'd13, 32'd0);
      run_prog("alu", 22);

      // Memory: stores, loads, ignored low address bits and modulo wrap
      add(i_op(6'h08, 5'd0, 5'd1, 16'd5),      1'b0, 5'd0, 32'd0);
      add(i_op(6'h08, 5'd0, 5'd3, 16'h1234),   1'b0, 5'd0, 32'd0);
      nops(3);
      add(i_op(6'h2B, 5'd0, 5'd1, 16'd8),      1'b0, 5'd0, 32'd0);
      add(i_op(6'h2B, 5'd0, 5'd3, 16'd134),    1'b0, 5'd0, 32'd0);
      add(i_op(6'h23, 5'd0, 5'd2, 16'd8),      1'b1, 5'd2, 32'd5);
      add(i_op(6'h23, 5'd0, 5'd4, 16'd5),      1'b1, 5'd4, 32'h0000_1234);
      add(i_op(6'h23, 5'd0, 5'd6, 16'hFF88),   1'b1, 5'd6, 32'd5);
      nops(3);
      add(r_op(6'h20, 5'd8, 5'd2, 5'd4),       1'b1, 5'd8, 32'h0000_1239);
      run_prog("mem", 20);
      check("mem word 2", dut.DM.memory[2], 32'd5);
      check("mem byte 8", {24'd0, dut.DM.Mem[8]}, 32'd5);
      check("mem byte 9", {24'd0, dut.DM.Mem[9]}, 32'd0);
      check("mem word 1 wrap", dut.DM.memory[1], 32'h0000_1234);
      check("mem byte 4 endian", {24'd0, dut.DM.Mem[4]}, 32'h0000_0034);

      // Branch: taken beq keeps its 3 trailing slots, then skips; untaken falls through
      add(i_op(6'h08, 5'd0, 5'd1, 16'd1),      1'b0, 5'd0, 32'd0);
      add(i_op(6'h08, 5'd0, 5'd2, 16'd1),      1'b0, 5'd0, 32'd0);
      nops(3);
      add(i_op(6'h04, 5'd1, 5'd2, 16'd4),      1'b0, 5'd0, 32'd0);
      add(i_op(6'h08, 5'd0, 5'd3, 16'd3),      1'b1, 5'd3, 32'd3);
      add(i_op(6'h08, 5'd0, 5'd4, 16'd4),      1'b1, 5'd4, 32'd4);
      add(i_op(6'h08, 5'd0, 5'd5, 16'd5),      1'b1, 5'd5, 32'd5);
      add(i_op(6'h08, 5'd0, 5'd9, 16'd99),     1'b1, 5'd9, 32'd0);
      add(i_op(6'h08, 5'd0, 5'd10, 16'd1),     1'b1, 5'd10, 32'd1);
      add(i_op(6'h04, 5'd1, 5'd3, 16'd4),      1'b0, 5'd0, 32'd0);
      add(i_op(6'h08, 5'd0, 5'd11, 16'd11),    1'b1, 5'd11, 32'd11);
      nops(2);
      add(i_op(6'h08, 5'd0, 5'd13, 16'd13),    1'b1, 5'd13, 32'd13);
      add(i_op(6'h08, 5'd0, 5'd14, 16'd14),    1'b1, 5'd14, 32'd14);
      run_prog("branch", 24);

      // Back-to-back dependents: results depend on whether forwarding is built in
      add(i_op(6'h08, 5'd0, 5'd1, 16'd4),      1'b1, 5'd1, 32'd4);
      add(r_op(6'h20, 5'd2, 5'd1, 5'd1),       1'b1, 5'd2, FWD ? 32'd8 : 32'd0);
      add(i_op(6'h08, 5'd0, 5'd3, 16'd6),      1'b0, 5'd0, 32'd0);
      nops(1);
      add(r_op(6'h20, 5'd4, 5'd3, 5'd3),       1'b1, 5'd4, FWD ? 32'd12 : 32'd0);
      add(i_op(6'h08, 5'd0, 5'd5, 16'd1),      1'b0, 5'd0, 32'd0);
      add(i_op(6'h08, 5'd0, 5'd5, 16'd2),      1'b1, 5'd5, 32'd2);
      add(r_op(6'h20, 5'd6, 5'd5, 5'd5),       1'b1, 5'd6, FWD ? 32'd4 : 32'd0);
      add(i_op(6'h08, 5'd0, 5'd7, 16'd9),      1'b0, 5'd0, 32'd0);
      nops(2);
      add(r_op(6'h20, 5'd8, 5'd7, 5'd7),       1'b1, 5'd8, 32'd18);
      run_prog("hazard", 18);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
